// File: rtl/signal_checker.sv
// One-hot phase sequence checker: acquires lock after LOCK_CNT in-order samples, flags and counts lock losses.
// Optional build macro SIGCHK_REVERSE_EN enables reverse-direction locking and the dir output.
module signal_checker #(
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [3:0]       in,
   output logic [1:0]       phase,
   output logic             phase_vld,
   output logic             locked,
   output logic             err,
`ifdef SIGCHK_REVERSE_EN
   output logic             dir,
`endif
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

   localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

   state_t             state_reg, state_next;
   logic [1:0]         exp_reg, exp_next;
   logic [3:0]         mcnt_reg, mcnt_next;
   logic               dir_reg, dir_next;
   logic               err_next;
   logic [1:0]         phase_reg;
   logic               phase_vld_reg;
   logic               locked_reg;
   logic               err_reg;
   logic [ERR_W-1:0]   err_cnt_reg;

   logic               sample_vld;
   logic [1:0]         sample_p;
   logic               fwd_match;
   logic               rev_first;
   logic               match_dir;

   always_comb begin
      sample_vld = 1'b1;
      sample_p   = 2'd0;
      case (in)
         4'b1000: sample_p = 2'd0;
         4'b0100: sample_p = 2'd1;
         4'b0010: sample_p = 2'd2;
         4'b0001: sample_p = 2'd3;
         default: sample_vld = 1'b0;
      endcase
   end

   // The first step after a fresh start decides direction; later steps follow dir_reg.
   always_comb begin
      fwd_match = sample_vld && (sample_p == exp_reg);
`ifdef SIGCHK_REVERSE_EN
      rev_first = sample_vld && (mcnt_reg == 4'd1) && (sample_p == exp_reg - 2'd2);
`else
      rev_first = 1'b0;
`endif
      match_dir = (mcnt_reg == 4'd1) ? rev_first : dir_reg;
   end

   always_comb begin
      state_next = state_reg;
      exp_next   = exp_reg;
      mcnt_next  = mcnt_reg;
      dir_next   = dir_reg;
      err_next   = 1'b0;
      case (state_reg)
         SEARCH: begin
            if (sample_vld) begin
               state_next = ACQUIRE;
               mcnt_next  = 4'd1;
               exp_next   = sample_p + 2'd1;
            end
         end
         ACQUIRE: begin
            if (!sample_vld) begin
               state_next = SEARCH;
               mcnt_next  = 4'd0;
               exp_next   = 2'd0;
               dir_next   = 1'b0;
            end else if (fwd_match || rev_first) begin
               dir_next  = match_dir;
               exp_next  = match_dir ? sample_p - 2'd1 : sample_p + 2'd1;
               mcnt_next = mcnt_reg + 4'd1;
               if (mcnt_reg + 4'd1 == LOCK_TARGET)
                  state_next = LOCKED;
            end else begin
               mcnt_next = 4'd1;
               exp_next  = sample_p + 2'd1;
            end
         end
         LOCKED: begin
            if (fwd_match) begin
               exp_next = dir_reg ? sample_p - 2'd1 : sample_p + 2'd1;
            end else begin
               // The breaking sample is dropped, so acquisition restarts from SEARCH.
               state_next = SEARCH;
               err_next   = 1'b1;
               mcnt_next  = 4'd0;
               exp_next   = 2'd0;
               dir_next   = 1'b0;
            end
         end
         default: begin
            state_next = SEARCH;
            mcnt_next  = 4'd0;
            exp_next   = 2'd0;
            dir_next   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_reg     <= SEARCH;
         exp_reg       <= 2'd0;
         mcnt_reg      <= 4'd0;
         dir_reg       <= 1'b0;
         phase_reg     <= 2'd0;
         phase_vld_reg <= 1'b0;
         locked_reg    <= 1'b0;
         err_reg       <= 1'b0;
         err_cnt_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         exp_reg       <= exp_next;
         mcnt_reg      <= mcnt_next;
         dir_reg       <= dir_next;
         phase_vld_reg <= sample_vld;
         if (sample_vld)
            phase_reg <= sample_p;
         locked_reg    <= (state_next == LOCKED);
         err_reg       <= err_next;
         if (err_next && (err_cnt_reg != {ERR_W{1'b1}}))
            err_cnt_reg <= err_cnt_reg + 1'b1;
      end
   end

   assign phase     = phase_reg;
   assign phase_vld = phase_vld_reg;
   assign locked    = locked_reg;
   assign err       = err_reg;
   assign err_cnt   = err_cnt_reg;
`ifdef SIGCHK_REVERSE_EN
   assign dir       = dir_reg;
`endif

endmodule

// File: tb/tb_signal_checker.sv
// Randomized and directed bench for signal_checker, checked every cycle against a run-length sequence model.
module tb_signal_checker;

   localparam int LOCK_CNT = 4;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] in  = 4'b0000;

   logic [1:0] phase, phase2;
   logic       phase_vld, phase_vld2, locked, locked2, err, err2;
   logic [7:0] err_cnt;
   logic [1:0] err_cnt2;
`ifdef SIGCHK_REVERSE_EN
   logic       dir, dir2;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   signal_checker #(.LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut (
      .clk(clk), .clr(clr), .in(in), .phase(phase), .phase_vld(phase_vld),
      .locked(locked), .err(err),
`ifdef SIGCHK_REVERSE_EN
      .dir(dir),
`endif
      .err_cnt(err_cnt));

   signal_checker #(.LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut2 (
      .clk(clk), .clr(clr), .in(in), .phase(phase2), .phase_vld(phase_vld2),
      .locked(locked2), .err(err2),
`ifdef SIGCHK_REVERSE_EN
      .dir(dir2),
`endif
      .err_cnt(err_cnt2));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: length of the current run of consecutive samples, each one step from the previous.
   int         m_run, m_cnt;
   logic [1:0] m_last, m_phase;
   logic       m_dir, m_locked, m_err, m_vld;

   always @(posedge clk or negedge clr) begin : model
      int         run, cnt;
      logic [1:0] last, p, ph;
      logic       dr, lk, er, vld;
      if (!clr) begin
         m_run <= 0; m_cnt <= 0; m_last <= 2'd0; m_phase <= 2'd0;
         m_dir <= 1'b0; m_locked <= 1'b0; m_err <= 1'b0; m_vld <= 1'b0;
      end else begin
         run = m_run; cnt = m_cnt; last = m_last; ph = m_phase;
         dr = m_dir; lk = m_locked; er = 1'b0;
         vld = ($countones(in) == 1);
         p = 2'd0;
         for (int b = 0; b < 4; b++)
            if (in[b]) p = 2'(3 - b);
         if (!vld) begin
            if (lk) begin er = 1'b1; cnt++; end
            lk = 1'b0; run = 0; dr = 1'b0;
         end else begin
            if (run == 0) begin
               run = 1;
            end else if (run == 1 && p == 2'(last + 1)) begin
               run = 2; dr = 1'b0;
`ifdef SIGCHK_REVERSE_EN
            end else if (run == 1 && p == 2'(last - 1)) begin
               run = 2; dr = 1'b1;
`endif
            end else if (run >= 2 && p == (dr ? 2'(last - 1) : 2'(last + 1))) begin
               run++;
            end else if (lk) begin
               er = 1'b1; cnt++; lk = 1'b0; run = 0; dr = 1'b0;
            end else begin
               run = 1;
            end
            if (run >= LOCK_CNT) lk = 1'b1;
            last = p; ph = p;
         end
         m_run <= run; m_cnt <= cnt; m_last <= last; m_phase <= ph;
         m_dir <= dr; m_locked <= lk; m_err <= er; m_vld <= vld;
      end
   end

   always @(negedge clk) begin
      cyc++;
      $display("cyc %0d clr=%b in=%b phase=%0d vld=%b locked=%b err=%b cnt=%0d cnt2=%0d",
               cyc, clr, in, phase, phase_vld, locked, err, err_cnt, err_cnt2);
      chk("phase", 32'(phase), 32'(m_phase));
      chk("phase_vld", 32'(phase_vld), 32'(m_vld));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("err", 32'(err), 32'(m_err));
      chk("err_cnt", 32'(err_cnt), (m_cnt > 255) ? 32'd255 : 32'(m_cnt));
      chk("err_cnt_w2", 32'(err_cnt2), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
      chk("locked_w2", 32'(locked2), 32'(m_locked));
`ifdef SIGCHK_REVERSE_EN
      chk("dir", 32'(dir), 32'(m_dir));
`endif
   end

   // Called at a falling edge; returns at the falling edge where v's result is visible.
   task automatic send(input logic [3:0] v);
      in = v;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 clr = 1'b0;
      #1 chk("async_reset_locked", 32'(locked), 32'd0);
      chk("async_reset_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      clr = 1'b1;
   endtask

   function automatic logic [3:0] onehot(input int p);
      logic [3:0] v;
      v = 4'b1000 >> (p & 3);
      return v;
   endfunction

   initial begin
      logic [3:0] seq32 [7];
      int p;
      seq32 = '{4'b1000, 4'b0100, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};

      repeat (3) @(negedge clk);
      chk("reset_phase", 32'(phase), 32'd0);
      chk("reset_locked", 32'(locked), 32'd0);
      chk("reset_err_cnt", 32'(err_cnt), 32'd0);
      clr = 1'b1;

      // Basic forward lock.
      for (int i = 0; i < 4; i++) begin
         send(onehot(i));
         chk("fwd_phase", 32'(phase), 32'(i));
         chk("fwd_locked", 32'(locked), (i == 3) ? 32'd1 : 32'd0);
      end
      chk("model_fwd_locked", 32'(m_locked), 32'd1);
      send(4'b1000);
      send(4'b0100);
      // Drop-out in place of phase 2.
      send(4'b0000);
      chk("drop_err", 32'(err), 32'd1);
      chk("drop_cnt", 32'(err_cnt), 32'd1);
      chk("drop_locked", 32'(locked), 32'd0);
      chk("model_drop_cnt", 32'(m_cnt), 32'd1);
      for (int i = 0; i < 4; i++) begin
         send(onehot(3 + i));
         chk("relock_err", 32'(err), 32'd0);
         chk("relock_locked", 32'(locked), (i == 3) ? 32'd1 : 32'd0);
      end
      // Multi-hot while locked; last phase was 2.
      send(4'b1100);
      chk("multihot_vld", 32'(phase_vld), 32'd0);
      chk("multihot_err", 32'(err), 32'd1);
      chk("multihot_cnt", 32'(err_cnt), 32'd2);
      chk("multihot_phase", 32'(phase), 32'd2);

      // Saturation on the narrow counter.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 4; i++) send(onehot(i));
         send(4'b0000);
         chk("sat_err", 32'(err2), 32'd1);
         chk("sat_cnt", 32'(err_cnt2), (k >= 2) ? 32'd3 : 32'(k + 1));
      end
      chk("sat_wide_cnt", 32'(err_cnt), 32'd5);

      // Repeated phase restarts acquisition.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         send(seq32[i]);
         chk("repeat_locked", 32'(locked), (i >= 5) ? 32'd1 : 32'd0);
         chk("repeat_err", 32'(err), 32'd0);
      end

      // Reverse sequence.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(onehot(3 - i));
`ifdef SIGCHK_REVERSE_EN
         chk("rev_locked", 32'(locked), (i >= 3) ? 32'd1 : 32'd0);
         if (i >= 1) chk("rev_dir", 32'(dir), 32'd1);
`else
         chk("rev_locked", 32'(locked), 32'd0);
`endif
      end

      // Randomized traffic.
      do_reset();
      p = 0;
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 80) p = p + 1;
         else if (r < 86) p = $urandom_range(0, 3);
`ifdef SIGCHK_REVERSE_EN
         else if (r < 90) p = p - 1;
`endif
         if (r >= 95) begin
            send(4'($urandom_range(0, 15)) & ((r & 1) ? 4'b1111 : 4'b0000));
         end else if (r >= 93) begin
            send(onehot(p));
         end else begin
            send(onehot(p));
         end
         if (n % 700 == 699) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
